audio_sample_mm_master: RTL and testbench
=========================================

// Module: audio_sample_mm_master
// PURPOSE
//  Avalon-MM initiator that drives the single-port on-chip sample RAM (s1) of the SoC.
//  Capture mode: writes N 32-bit audio words from a valid/ready sink into RAM.
//  Playback mode: reads N words back and presents them on a valid/ready source.
//  Target has no waitrequest; read data returns a fixed READ_LATENCY cycles after the request.
// PARAMETERS
//  ADDR_W        2   word-address width of target RAM; addresses wrap modulo 2**ADDR_W
//  DATA_W        32  sample/bus width; byteenable width = DATA_W/8
//  READ_LATENCY  1   cycles from read request (chipselect & ~write) to valid avm_readdata; >=1
// PORTS
//  clk             in   1           sole clock
//  reset_n         in   1           asynchronous active-low reset
//  cmd_start       in   1           start pulse; accepted only when busy=0
//  cmd_write       in   1           1=capture (write RAM), 0=playback (read RAM); sampled at start
//  cmd_base        in   ADDR_W      first word address; sampled at start
//  cmd_len         in   ADDR_W+1    word count 0..2**ADDR_W; sampled at start
//  cmd_stop        in   1           abort current transfer
//  busy            out  1           high while not IDLE
//  done            out  1           one-cycle pulse at end (normal or aborted)
//  snk_data        in   DATA_W      capture samples
//  snk_valid       in   1
//  snk_ready       out  1           high only in WRITE state
//  src_data        out  DATA_W      playback samples (registered)
//  src_valid       out  1           held until src_ready
//  src_ready       in   1
//  avm_address     out  ADDR_W      word address
//  avm_chipselect  out  1
//  avm_write       out  1
//  avm_writedata   out  DATA_W      = snk_data
//  avm_byteenable  out  DATA_W/8    all ones
//  avm_clken       out  1           tied 1
//  avm_readdata    in   DATA_W
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, src_valid, avm_chipselect, avm_write = 0; src_data, addr, count = 0.
//  Reset mid-transfer aborts immediately; no partial write completes after reset_n falls.
//  States: IDLE, WRITE, RD_REQ, RD_WAIT, RD_OUT, FIN.
//  IDLE: cmd_start -> latch base/len/mode; len=0 -> FIN; else WRITE or RD_REQ.
//  WRITE: snk_ready=1; each cycle snk_valid=1 issues avm_chipselect=avm_write=1 at addr
//    (combinational, same cycle), then addr+1 (wrap), count-1; last word -> FIN.
//  RD_REQ: avm_chipselect=1, avm_write=0 for exactly one cycle -> RD_WAIT.
//  RD_WAIT: counts READ_LATENCY-1 further cycles; on the cycle avm_readdata is valid,
//    register it into src_data, set src_valid -> RD_OUT.
//  RD_OUT: hold src_data/src_valid until src_ready; then addr+1, count-1;
//    count was 1 -> FIN, else RD_REQ. One read outstanding at a time.
//  FIN: done=1 for one cycle, busy drops next cycle -> IDLE.
//  Throughput: capture 1 word/cycle; playback best case 1 word per READ_LATENCY+2 cycles.
//  cmd_stop: in WRITE/RD_REQ -> FIN at once, no further bus cycles.
//    In RD_WAIT, completes the pending read, discards data -> FIN.
//    In RD_OUT, drops src_valid -> FIN. Ignored in IDLE/FIN.
//  cmd_start while busy is ignored; cmd_start and cmd_stop together in IDLE: start wins.
//  Address wrap: base=3, len=3, ADDR_W=2 -> addresses 3,0,1.
// CONFIGURATION
//  LOOP_PLAYBACK_EN defined: in playback, after the last word, reload addr=base, count=len
//    and continue (RD_REQ); ends only via cmd_stop; done pulses on stop only.
//  LOOP_PLAYBACK_EN undefined: playback ends after len words as above.
//  Capture unaffected.
// TESTING
//  1 capture base=0 len=4, snk words A0..A3 back-to-back -> writes addr 0..3 in 4 consecutive cycles, done at cycle 5
//  2 playback base=0 len=4 with src_ready=1 -> src emits A0..A3 in order; one chipselect per word; done once
//  3 wrap: capture base=3 len=3 -> avm_address 3,0,1; playback with src_ready stalled 5 cycles -> src_data stable, no extra reads
//  4 len=0 start -> no chipselect, done one cycle after start, busy high 1 cycle
//  5 cmd_stop during RD_WAIT and mid-capture after 2 words -> no further bus cycles, done pulse, busy=0; reset_n low mid-WRITE -> all outputs 0 async
//  6 LOOP_PLAYBACK_EN, len=2 base=1 -> src sequence W1,W2,W1,W2... until cmd_stop; done only at stop

Source files
------------

// File: rtl/audio_sample_mm_master.sv
// Avalon-MM initiator for the sample RAM: capture (sink -> RAM) and playback (RAM -> source).
// Build option: LOOP_PLAYBACK_EN restarts playback at the base address until cmd_stop.
module audio_sample_mm_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_start,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [ADDR_W:0]     cmd_len,
    input  logic                cmd_stop,
    output logic                busy,
    output logic                done,
    input  logic [DATA_W-1:0]   snk_data,
    input  logic                snk_valid,
    output logic                snk_ready,
    output logic [DATA_W-1:0]   src_data,
    output logic                src_valid,
    input  logic                src_ready,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_clken,
    input  logic [DATA_W-1:0]   avm_readdata
);
    localparam int STAGES = READ_LATENCY - 1;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, RD_OUT, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic              stop_pend;
    logic              rd_issue;
    logic              rd_valid;
    logic [STAGES:0]   vld_pipe;
`ifdef LOOP_PLAYBACK_EN
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
`endif

    // A stop in WRITE/RD_REQ must suppress the bus cycle of that same clock
    assign snk_ready      = (state == WRITE);
    assign avm_write      = (state == WRITE) && snk_valid && !cmd_stop;
    assign rd_issue       = (state == RD_REQ) && !cmd_stop;
    assign avm_chipselect = avm_write || rd_issue;
    assign avm_address    = addr;
    assign avm_writedata  = snk_data;
    assign avm_byteenable = '1;
    assign avm_clken      = 1'b1;
    assign rd_valid       = vld_pipe[STAGES];

    // Tracks the outstanding read; top bit marks the cycle avm_readdata is valid
    generate
        if (STAGES == 0) begin : g_pipe1
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) vld_pipe <= '0;
                else          vld_pipe <= rd_issue;
        end else begin : g_pipen
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) vld_pipe <= '0;
                else          vld_pipe <= {vld_pipe[STAGES-1:0], rd_issue};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            src_valid <= 1'b0;
            src_data  <= '0;
            addr      <= '0;
            count     <= '0;
            stop_pend <= 1'b0;
`ifdef LOOP_PLAYBACK_EN
            base_q    <= '0;
            len_q     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_start) begin
                    addr      <= cmd_base;
                    count     <= cmd_len;
                    stop_pend <= 1'b0;
                    busy      <= 1'b1;
`ifdef LOOP_PLAYBACK_EN
                    base_q    <= cmd_base;
                    len_q     <= cmd_len;
`endif
                    if (cmd_len == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= cmd_write ? WRITE : RD_REQ;
                    end
                end
                WRITE: if (cmd_stop) begin
                    state <= FIN;
                    done  <= 1'b1;
                end else if (snk_valid) begin
                    addr  <= addr + 1'b1;
                    count <= count - 1'b1;
                    if (count == ONE) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                RD_REQ: if (cmd_stop) begin
                    state <= FIN;
                    done  <= 1'b1;
                end else begin
                    state <= RD_WAIT;
                end
                // The pending read always completes; a stop seen meanwhile discards it
                RD_WAIT: if (rd_valid) begin
                    if (stop_pend || cmd_stop) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        src_data  <= avm_readdata;
                        src_valid <= 1'b1;
                        state     <= RD_OUT;
                    end
                end else if (cmd_stop) begin
                    stop_pend <= 1'b1;
                end
                RD_OUT: if (cmd_stop) begin
                    src_valid <= 1'b0;
                    state     <= FIN;
                    done      <= 1'b1;
                end else if (src_ready) begin
                    src_valid <= 1'b0;
                    addr      <= addr + 1'b1;
                    count     <= count - 1'b1;
                    if (count == ONE) begin
`ifdef LOOP_PLAYBACK_EN
                        addr  <= base_q;
                        count <= len_q;
                        state <= RD_REQ;
`else
                        state <= FIN;
                        done  <= 1'b1;
`endif
                    end else begin
                        state <= RD_REQ;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_sample_mm_master.sv
// Bench for audio_sample_mm_master: RAM model on the bus, bus/stream monitor, and an
// address-arithmetic reference (expected memory image) for capture and playback.
module tb_audio_sample_mm_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0, cmd_write = 1'b0, cmd_stop = 1'b0;
    logic [1:0]  cmd_base = '0;
    logic [2:0]  cmd_len = '0;
    logic        busy, done;
    logic [31:0] snk_data = '0;
    logic        snk_valid = 1'b0, snk_ready;
    logic [31:0] src_data;
    logic        src_valid, src_ready = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write, avm_clken;
    logic [31:0] avm_writedata, avm_readdata;
    logic [3:0]  avm_byteenable;

    audio_sample_mm_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .cmd_stop(cmd_stop), .busy(busy), .done(done),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_clken(avm_clken), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    // Target RAM, read latency 1
    logic [31:0] mem [4];
    always @(posedge clk) begin
        if (avm_chipselect && avm_write) mem[avm_address] <= avm_writedata;
        if (avm_chipselect && !avm_write) avm_readdata <= mem[avm_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    int done_cnt = 0, done_cyc = 0, rd_cnt = 0, busy_cnt = 0, valid_cnt = 0, unstable = 0;
    logic [1:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] src_q[$];
    logic [31:0] exp_mem [4];
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;

    always @(negedge clk) if (reset_n) begin
        if (avm_chipselect && avm_write) begin
            wr_addr_q.push_back(avm_address);
            wr_data_q.push_back(avm_writedata);
            wr_cyc_q.push_back(cyc);
        end
        if (avm_chipselect && !avm_write) rd_cnt++;
        if (src_valid && src_ready) src_q.push_back(src_data);
        if (src_valid) valid_cnt++;
        if (busy) busy_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (pv && !pr && (!src_valid || src_data !== pd)) unstable++;
        pv = src_valid; pr = src_ready; pd = src_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int d0);
        int g = 0;
        while (done_cnt == d0 && g < 300) begin step(); g++; end
        chk("done_timeout", 64'(g < 300), 1);
        step();
    endtask

    task automatic start(input logic wr, input int b, input int n);
        cmd_write = wr; cmd_base = 2'(b); cmd_len = 3'(n); cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
    endtask

    task automatic cap(input int b, input int n, input bit gaps);
        logic [31:0] d [4];
        int w0 = wr_addr_q.size(), d0 = done_cnt, st = cyc, i = 0, g = 0;
        for (int k = 0; k < 4; k++) d[k] = $urandom;
        start(1'b1, b, n);
        while (i < n && g < 100) begin
            snk_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            snk_data  = d[i];
            @(negedge clk);
            if (snk_valid && snk_ready) i++;
            step(); g++;
        end
        snk_valid = 1'b0;
        wait_done(d0);
        for (int k = 0; k < n; k++) exp_mem[(b + k) % 4] = d[k];
        chk("cap_nwr", 64'(wr_addr_q.size() - w0), 64'(n));
        chk("cap_done", 64'(done_cnt - d0), 1);
        for (int k = 0; k < n && w0 + k < wr_addr_q.size(); k++) begin
            chk("cap_addr", wr_addr_q[w0 + k], 64'((b + k) % 4));
            chk("cap_data", wr_data_q[w0 + k], d[k]);
            if (!gaps) chk("cap_wcyc", 64'(wr_cyc_q[w0 + k] - st), 64'(k + 1));
        end
        if (!gaps) chk("cap_done_cyc", 64'(done_cyc - st), 64'(n + 1));
    endtask

    task automatic play(input int b, input int n, input bit rnd);
        int s0 = src_q.size(), r0 = rd_cnt, d0 = done_cnt, g = 0;
        start(1'b0, b, n);
        while (done_cnt == d0 && g < 300) begin
            src_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step(); g++;
        end
        chk("play_timeout", 64'(g < 300), 1);
        step();
        src_ready = 1'b0;
        chk("play_n", 64'(src_q.size() - s0), 64'(n));
        chk("play_reads", 64'(rd_cnt - r0), 64'(n));
        chk("play_done", 64'(done_cnt - d0), 1);
        for (int k = 0; k < n && s0 + k < src_q.size(); k++)
            chk("play_data", src_q[s0 + k], exp_mem[(b + k) % 4]);
    endtask

    initial begin
        int w0, r0, d0, s0, b0, v0;
        #2;
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_srcv", src_valid, 0); chk("rst_cs", avm_chipselect, 0);
        chk("rst_wr", avm_write, 0);   chk("rst_srcd", src_data, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_be", avm_byteenable, 4'hf); chk("rst_clken", avm_clken, 1);
        step(); reset_n = 1'b1; step();

        cap(0, 4, 0);
`ifndef LOOP_PLAYBACK_EN
        play(0, 4, 0);
`endif
        b0 = busy_cnt; r0 = rd_cnt;
        cap(1, 0, 0);
        chk("len0_busy", 64'(busy_cnt - b0), 1);
        chk("len0_rd", 64'(rd_cnt - r0), 0);

        cap(3, 3, 0);
`ifndef LOOP_PLAYBACK_EN
        s0 = src_q.size(); d0 = done_cnt;
        start(1'b0, 3, 3);
        for (int g = 0; g < 20 && !src_valid; g++) step();
        r0 = rd_cnt;
        repeat (5) step();
        chk("stall_valid", src_valid, 1);
        chk("stall_data", src_data, exp_mem[3]);
        chk("stall_reads", 64'(rd_cnt - r0), 0);
        src_ready = 1'b1;
        wait_done(d0);
        src_ready = 1'b0;
        chk("stall_n", 64'(src_q.size() - s0), 3);
        for (int k = 0; k < 3 && s0 + k < src_q.size(); k++)
            chk("stall_seq", src_q[s0 + k], exp_mem[(3 + k) % 4]);
        chk("stall_stable", 64'(unstable), 0);
`endif

        // stop while the read is outstanding
        r0 = rd_cnt; d0 = done_cnt; v0 = valid_cnt; src_ready = 1'b1;
        start(1'b0, 0, 4);
        step();
        cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
        wait_done(d0);
        src_ready = 1'b0;
        chk("stopr_reads", 64'(rd_cnt - r0), 1);
        chk("stopr_valid", 64'(valid_cnt - v0), 0);
        chk("stopr_done", 64'(done_cnt - d0), 1);
        chk("stopr_busy", busy, 0);

        // stop mid-capture after two words
        w0 = wr_addr_q.size(); d0 = done_cnt;
        start(1'b1, 2, 4);
        snk_valid = 1'b1; snk_data = $urandom; exp_mem[2] = snk_data; step();
        snk_data = $urandom; exp_mem[3] = snk_data; step();
        snk_data = $urandom; cmd_stop = 1'b1; step(); cmd_stop = 1'b0; snk_valid = 1'b0;
        wait_done(d0);
        chk("stopw_nwr", 64'(wr_addr_q.size() - w0), 2);
        chk("stopw_done", 64'(done_cnt - d0), 1);
        chk("stopw_busy", busy, 0);

        // asynchronous reset in the middle of a capture
        w0 = wr_addr_q.size();
        start(1'b1, 0, 4);
        snk_valid = 1'b1; snk_data = $urandom; exp_mem[0] = snk_data; step();
        snk_data = $urandom;
        #2 reset_n = 1'b0; #1;
        chk("arst_cs", avm_chipselect, 0); chk("arst_wr", avm_write, 0);
        chk("arst_busy", busy, 0);         chk("arst_done", done, 0);
        chk("arst_srcv", src_valid, 0);    chk("arst_addr", avm_address, 0);
        chk("arst_rdy", snk_ready, 0);
        snk_valid = 1'b0;
        step(); reset_n = 1'b1; step();
        chk("arst_nwr", 64'(wr_addr_q.size() - w0), 1);

        for (int it = 0; it < 6; it++) begin
            int b = $urandom_range(0, 3), n = $urandom_range(0, 4);
            cap(b, n, 1);
`ifndef LOOP_PLAYBACK_EN
            play(b, n, 1);
`endif
        end

`ifdef LOOP_PLAYBACK_EN
        begin
            int n;
            cap(0, 4, 0);
            s0 = src_q.size(); d0 = done_cnt; src_ready = 1'b1;
            start(1'b0, 1, 2);
            repeat (20) step();
            chk("loop_nodone", 64'(done_cnt - d0), 0);
            src_ready = 1'b0; cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
            wait_done(d0);
            chk("loop_done", 64'(done_cnt - d0), 1);
            n = src_q.size() - s0;
            chk("loop_len", 64'(n >= 4), 1);
            for (int k = 0; k < n; k++) chk("loop_seq", src_q[s0 + k], exp_mem[1 + (k % 2)]);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
